priority_resolver: RTL and testbench

PRIORITY_RESOLVER -- requirements
Module: priority_resolver

---
 rtl/pic_pkg.sv | 28 ++
 rtl/pic_prio_enc.sv | 29 ++
 rtl/priority_resolver.sv | 210 +++++++++++++++++++++
 tb/tb_priority_resolver.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt priority resolver.
//   IR_COUNT   : number of interrupt request lines (8)
//   LEVEL_W    : width of a priority level / IR index (3)
//   pic_state_t: acknowledge sequencer states (IDLE, ACK2)
//   prio_rank  : distance of a level from the priority pointer (0 = highest)
//   level_bit  : one-hot mask for a level
package pic_pkg;

  localparam int LEVEL_W  = 3;
  localparam int IR_COUNT = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK2 = 1'b1
  } pic_state_t;

  // The pointer names the highest-priority level; rank grows towards lower
  // priority, wrapping modulo 8.
  function automatic logic [LEVEL_W-1:0] prio_rank(input logic [LEVEL_W-1:0] level,
                                                   input logic [LEVEL_W-1:0] ptr);
    return level - ptr;
  endfunction

  function automatic logic [IR_COUNT-1:0] level_bit(input logic [LEVEL_W-1:0] level);
    return IR_COUNT'(1) << level;
  endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Rotating priority encoder.
// Returns the index of the set bit of vec that is closest to ptr, scanning
// ptr, ptr+1, ... ptr+7 (mod 8).
//   vec : input request/service vector
//   ptr : level that currently has the highest priority
//   idx : winning index (0 when any = 0)
//   any : at least one bit of vec is set
module pic_prio_enc
  import pic_pkg::*;
(
  input  logic [IR_COUNT-1:0] vec,
  input  logic [LEVEL_W-1:0]  ptr,
  output logic [LEVEL_W-1:0]  idx,
  output logic                any
);

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = IR_COUNT - 1; i >= 0; i--) begin
      if (vec[ptr + LEVEL_W'(i)]) begin
        idx = ptr + LEVEL_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_resolver.sv
// Interrupt priority resolver in the style of an 8259 core: IR
// synchronization, request register, in-service register, priority
// arbitration and the two-strobe interrupt acknowledge sequence.
//
// Build option: define ROTATE_ON_EOI_EN to add the ROTATE input and a
// rotating priority pointer (non-specific EOI with ROTATE = 1 makes the
// cleared level lowest priority). Without it priority is fixed, IR0 highest.
//
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   IR[7:0]         : asynchronous interrupt requests
//   LTIM            : 1 = level-triggered, 0 = edge-triggered
//   Interrupt_Mask  : bit n = 1 masks IRn
//   INTA_STB        : one strobe per INTA# falling edge
//   EOI_NS, EOI_SP  : non-specific / specific EOI strobes
//   EOI_LEVEL       : level cleared by EOI_SP
//   AEOI            : automatic EOI at the second acknowledge
//   VEC_BASE        : vector bits T7..T3
//   ROTATE          : (ROTATE_ON_EOI_EN only) rotate on non-specific EOI
//   INT             : registered interrupt request to the CPU
//   VECTOR          : {VEC_BASE, level}, qualified by VEC_VALID
//   VEC_VALID       : one-cycle vector qualifier
//   IRR, ISR        : request and in-service registers
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | arbitrating; INT follows the winner; first INTA latches the level
// ACK2  | level latched; second INTA presents the vector and returns to IDLE
module priority_resolver
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2  // legal range 2..3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IR_COUNT-1:0] IR,
  input  logic                LTIM,
  input  logic [IR_COUNT-1:0] Interrupt_Mask,
  input  logic                INTA_STB,
  input  logic                EOI_NS,
  input  logic                EOI_SP,
  input  logic [LEVEL_W-1:0]  EOI_LEVEL,
  input  logic                AEOI,
  input  logic [4:0]          VEC_BASE,
`ifdef ROTATE_ON_EOI_EN
  input  logic                ROTATE,
`endif
  output logic                INT,
  output logic [7:0]          VECTOR,
  output logic                VEC_VALID,
  output logic [IR_COUNT-1:0] IRR,
  output logic [IR_COUNT-1:0] ISR
);

  logic [IR_COUNT-1:0] sync_q [SYNC_STAGES];
  logic [IR_COUNT-1:0] ir_s;
  logic [IR_COUNT-1:0] ir_prev;

  logic [IR_COUNT-1:0] irr_q;
  logic [IR_COUNT-1:0] isr_q;
  pic_state_t          state;
  logic                int_q;
  logic [7:0]          vector_q;
  logic                vec_valid_q;
  logic [LEVEL_W-1:0]  level_q;
  logic                spurious_q;

  logic [LEVEL_W-1:0]  ptr;

  logic [LEVEL_W-1:0]  isr_top_idx;
  logic                isr_top_any;
  logic [IR_COUNT-1:0] eoi_clr;
  logic [IR_COUNT-1:0] isr_eff;
  logic [LEVEL_W-1:0]  eff_idx;
  logic                eff_any;
  logic [IR_COUNT-1:0] cand;
  logic [LEVEL_W-1:0]  cand_idx;
  logic                cand_any;
  logic                winner;
  logic                ack_win;
  logic [IR_COUNT-1:0] ack_clr;
  logic [IR_COUNT-1:0] aeoi_clr;
  logic [IR_COUNT-1:0] rise;
  logic [IR_COUNT-1:0] irr_next;
  logic [IR_COUNT-1:0] isr_next;

  // IR synchronizer plus one extra flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      ir_prev <= '0;
    end else begin
      sync_q[0] <= IR;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      ir_prev <= ir_s;
    end
  end

  assign ir_s = sync_q[SYNC_STAGES-1];

`ifdef ROTATE_ON_EOI_EN
  // Rotation only on a non-specific EOI that actually clears a bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (EOI_NS && !EOI_SP && ROTATE && isr_top_any) begin
      ptr <= isr_top_idx + LEVEL_W'(1);
    end
  end
`else
  assign ptr = '0;
`endif

  pic_prio_enc u_isr_top (
    .vec (isr_q),
    .ptr (ptr),
    .idx (isr_top_idx),
    .any (isr_top_any)
  );

  // EOI is folded into the ISR before arbitration so a bit cleared this
  // cycle no longer blocks a request acknowledged in the same cycle.
  always_comb begin
    eoi_clr = '0;
    if (EOI_SP) begin
      eoi_clr = level_bit(EOI_LEVEL);
    end else if (EOI_NS && isr_top_any) begin
      eoi_clr = level_bit(isr_top_idx);
    end
  end

  assign isr_eff = isr_q & ~eoi_clr;

  pic_prio_enc u_isr_eff (
    .vec (isr_eff),
    .ptr (ptr),
    .idx (eff_idx),
    .any (eff_any)
  );

  assign cand = irr_q & ~Interrupt_Mask;

  pic_prio_enc u_cand (
    .vec (cand),
    .ptr (ptr),
    .idx (cand_idx),
    .any (cand_any)
  );

  // A candidate must strictly outrank every in-service level; a request on
  // a level already in service never wins.
  assign winner = cand_any &&
                  (!eff_any || (prio_rank(cand_idx, ptr) < prio_rank(eff_idx, ptr)));

  assign ack_win  = (state == IDLE) && INTA_STB && winner;
  assign ack_clr  = ack_win ? level_bit(cand_idx) : '0;
  assign aeoi_clr = ((state == ACK2) && INTA_STB && AEOI && !spurious_q) ?
                    level_bit(level_q) : '0;

  assign rise     = ir_s & ~ir_prev;
  assign irr_next = LTIM ? (ir_s & ~ack_clr)
                         : ((irr_q | rise) & ir_s & ~ack_clr);
  assign isr_next = (isr_eff | ack_clr) & ~aeoi_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      irr_q       <= '0;
      isr_q       <= '0;
      int_q       <= 1'b0;
      vector_q    <= '0;
      vec_valid_q <= 1'b0;
      level_q     <= '0;
      spurious_q  <= 1'b0;
    end else begin
      irr_q       <= irr_next;
      isr_q       <= isr_next;
      vec_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          int_q <= winner && !INTA_STB;
          if (INTA_STB) begin
            state      <= ACK2;
            level_q    <= winner ? cand_idx : LEVEL_W'(7);
            spurious_q <= !winner;
          end
        end
        ACK2: begin
          int_q <= 1'b0;
          if (INTA_STB) begin
            state       <= IDLE;
            vec_valid_q <= 1'b1;
            vector_q    <= {VEC_BASE, level_q};
          end
        end
        default: begin
          state <= IDLE;
          int_q <= 1'b0;
        end
      endcase
    end
  end

  assign INT       = int_q;
  assign VECTOR    = vector_q;
  assign VEC_VALID = vec_valid_q;
  assign IRR       = irr_q;
  assign ISR       = isr_q;

endmodule

// File: tb/tb_priority_resolver.sv
// Directed bench for priority_resolver (SYNC_STAGES = 2, VEC_BASE = 5'h08).
// A cycle-by-cycle vector table covers the main flows; short hand-written
// sequences cover spurious ack, EOI precedence, EOI-before-arbitration,
// reset during ACK2 and (with ROTATE_ON_EOI_EN) rotation.
module tb_priority_resolver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] IR;
  logic       LTIM;
  logic [7:0] Interrupt_Mask;
  logic       INTA_STB;
  logic       EOI_NS;
  logic       EOI_SP;
  logic [2:0] EOI_LEVEL;
  logic       AEOI;
  logic [4:0] VEC_BASE;
`ifdef ROTATE_ON_EOI_EN
  logic       ROTATE;
`endif
  logic       INT;
  logic [7:0] VECTOR;
  logic       VEC_VALID;
  logic [7:0] IRR;
  logic [7:0] ISR;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  priority_resolver #(.SYNC_STAGES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .IR             (IR),
    .LTIM           (LTIM),
    .Interrupt_Mask (Interrupt_Mask),
    .INTA_STB       (INTA_STB),
    .EOI_NS         (EOI_NS),
    .EOI_SP         (EOI_SP),
    .EOI_LEVEL      (EOI_LEVEL),
    .AEOI           (AEOI),
    .VEC_BASE       (VEC_BASE),
`ifdef ROTATE_ON_EOI_EN
    .ROTATE         (ROTATE),
`endif
    .INT            (INT),
    .VECTOR         (VECTOR),
    .VEC_VALID      (VEC_VALID),
    .IRR            (IRR),
    .ISR            (ISR)
  );

  typedef struct packed {
    logic       rst;
    logic [7:0] ir;
    logic [7:0] mask;
    logic       ltim;
    logic       aeoi;
    logic       inta;
    logic       ens;
    logic       esp;
    logic [2:0] elev;
    logic [25:0] exp_out;  // {INT, VEC_VALID, VECTOR, IRR, ISR}
  } vec_t;

  vec_t tbl [58];

  function automatic vec_t mk(input logic rst, input logic [7:0] ir, input logic [7:0] mask,
                              input logic ltim, input logic aeoi, input logic inta,
                              input logic ens, input logic esp, input logic [2:0] elev,
                              input logic e_int, input logic e_vv, input logic [7:0] e_vec,
                              input logic [7:0] e_irr, input logic [7:0] e_isr);
    vec_t v;
    v.rst = rst; v.ir = ir; v.mask = mask; v.ltim = ltim; v.aeoi = aeoi;
    v.inta = inta; v.ens = ens; v.esp = esp; v.elev = elev;
    v.exp_out = {e_int, e_vv, e_vec, e_irr, e_isr};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic inta_pair();
    INTA_STB = 1'b1;
    tick();
    tick();
    INTA_STB = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; IR = '0; LTIM = 1'b0; Interrupt_Mask = '0; INTA_STB = 1'b0;
    EOI_NS = 1'b0; EOI_SP = 1'b0; EOI_LEVEL = '0; AEOI = 1'b0; VEC_BASE = 5'h08;
`ifdef ROTATE_ON_EOI_EN
    ROTATE = 1'b0;
`endif

    //             rst ir    mask  lt ae ia ns sp lv   int vv vec    irr    isr
    tbl[0]  = mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h00, 8'h00, 8'h00);
    tbl[1]  = mk(0, 8'h04, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h00, 8'h00, 8'h00);
    tbl[2]  = mk(0, 8'h04, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h00, 8'h00, 8'h00);
    tbl[3]  = mk(0, 8'h04, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h00, 8'h04, 8'h00);
    tbl[4]  = mk(0, 8'h04, 8'h00, 0, 0, 0, 0, 0, 0,   1, 0, 8'h00, 8'h04, 8'h00);
    tbl[5]  = mk(0, 8'h04, 8'h00, 0, 0, 1, 0, 0, 0,   0, 0, 8'h00, 8'h00, 8'h04);
    tbl[6]  = mk(0, 8'h04, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h00, 8'h00, 8'h04);
    tbl[7]  = mk(0, 8'h04, 8'h00, 0, 0, 1, 0, 0, 0,   0, 1, 8'h42, 8'h00, 8'h04);
    tbl[8]  = mk(0, 8'h04, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h42, 8'h00, 8'h04);
    tbl[9]  = mk(0, 8'h04, 8'h00, 0, 0, 0, 1, 0, 0,   0, 0, 8'h42, 8'h00, 8'h00);
    tbl[10] = mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h42, 8'h00, 8'h00);
    // IR5 served, then IR3 preempts it
    tbl[11] = mk(0, 8'h20, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h42, 8'h00, 8'h00);
    tbl[12] = mk(0, 8'h20, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h42, 8'h00, 8'h00);
    tbl[13] = mk(0, 8'h20, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h42, 8'h20, 8'h00);
    tbl[14] = mk(0, 8'h20, 8'h00, 0, 0, 0, 0, 0, 0,   1, 0, 8'h42, 8'h20, 8'h00);
    tbl[15] = mk(0, 8'h20, 8'h00, 0, 0, 1, 0, 0, 0,   0, 0, 8'h42, 8'h00, 8'h20);
    tbl[16] = mk(0, 8'h20, 8'h00, 0, 0, 1, 0, 0, 0,   0, 1, 8'h45, 8'h00, 8'h20);
    tbl[17] = mk(0, 8'h28, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h45, 8'h00, 8'h20);
    tbl[18] = mk(0, 8'h28, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h45, 8'h00, 8'h20);
    tbl[19] = mk(0, 8'h28, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h45, 8'h08, 8'h20);
    tbl[20] = mk(0, 8'h28, 8'h00, 0, 0, 0, 0, 0, 0,   1, 0, 8'h45, 8'h08, 8'h20);
    tbl[21] = mk(0, 8'h28, 8'h00, 0, 0, 1, 0, 0, 0,   0, 0, 8'h45, 8'h00, 8'h28);
    tbl[22] = mk(0, 8'h28, 8'h00, 0, 0, 1, 0, 0, 0,   0, 1, 8'h43, 8'h00, 8'h28);
    tbl[23] = mk(0, 8'h28, 8'h00, 0, 0, 0, 1, 0, 0,   0, 0, 8'h43, 8'h00, 8'h20);
    // IR7 blocked by IR5 in service until EOI_NS
    tbl[24] = mk(0, 8'hA8, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h43, 8'h00, 8'h20);
    tbl[25] = mk(0, 8'hA8, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h43, 8'h00, 8'h20);
    tbl[26] = mk(0, 8'hA8, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h43, 8'h80, 8'h20);
    tbl[27] = mk(0, 8'hA8, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h43, 8'h80, 8'h20);
    tbl[28] = mk(0, 8'hA8, 8'h00, 0, 0, 0, 1, 0, 0,   1, 0, 8'h43, 8'h80, 8'h00);
    tbl[29] = mk(0, 8'hA8, 8'h00, 0, 0, 1, 0, 0, 0,   0, 0, 8'h43, 8'h00, 8'h80);
    tbl[30] = mk(0, 8'hA8, 8'h00, 0, 0, 1, 0, 0, 0,   0, 1, 8'h47, 8'h00, 8'h80);
    tbl[31] = mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 7,   0, 0, 8'h47, 8'h00, 8'h00);
    tbl[32] = mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h47, 8'h00, 8'h00);
    tbl[33] = mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h47, 8'h00, 8'h00);
    // masked IR2, then unmasked
    tbl[34] = mk(0, 8'h04, 8'h04, 0, 0, 0, 0, 0, 0,   0, 0, 8'h47, 8'h00, 8'h00);
    tbl[35] = mk(0, 8'h04, 8'h04, 0, 0, 0, 0, 0, 0,   0, 0, 8'h47, 8'h00, 8'h00);
    tbl[36] = mk(0, 8'h04, 8'h04, 0, 0, 0, 0, 0, 0,   0, 0, 8'h47, 8'h04, 8'h00);
    tbl[37] = mk(0, 8'h04, 8'h04, 0, 0, 0, 0, 0, 0,   0, 0, 8'h47, 8'h04, 8'h00);
    tbl[38] = mk(0, 8'h04, 8'h00, 0, 0, 0, 0, 0, 0,   1, 0, 8'h47, 8'h04, 8'h00);
    tbl[39] = mk(0, 8'h04, 8'h00, 0, 0, 1, 0, 0, 0,   0, 0, 8'h47, 8'h00, 8'h04);
    tbl[40] = mk(0, 8'h04, 8'h00, 0, 0, 1, 0, 0, 0,   0, 1, 8'h42, 8'h00, 8'h04);
    tbl[41] = mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 2,   0, 0, 8'h42, 8'h00, 8'h00);
    // AEOI with IR4
    tbl[42] = mk(0, 8'h10, 8'h00, 0, 1, 0, 0, 0, 0,   0, 0, 8'h42, 8'h00, 8'h00);
    tbl[43] = mk(0, 8'h10, 8'h00, 0, 1, 0, 0, 0, 0,   0, 0, 8'h42, 8'h00, 8'h00);
    tbl[44] = mk(0, 8'h10, 8'h00, 0, 1, 0, 0, 0, 0,   0, 0, 8'h42, 8'h10, 8'h00);
    tbl[45] = mk(0, 8'h10, 8'h00, 0, 1, 0, 0, 0, 0,   1, 0, 8'h42, 8'h10, 8'h00);
    tbl[46] = mk(0, 8'h10, 8'h00, 0, 1, 1, 0, 0, 0,   0, 0, 8'h42, 8'h00, 8'h10);
    tbl[47] = mk(0, 8'h10, 8'h00, 0, 1, 1, 0, 0, 0,   0, 1, 8'h44, 8'h00, 8'h00);
    tbl[48] = mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h44, 8'h00, 8'h00);
    tbl[49] = mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h44, 8'h00, 8'h00);
    // level mode IR6: IRR forced low only in the ack cycle
    tbl[50] = mk(0, 8'h40, 8'h00, 1, 0, 0, 0, 0, 0,   0, 0, 8'h44, 8'h00, 8'h00);
    tbl[51] = mk(0, 8'h40, 8'h00, 1, 0, 0, 0, 0, 0,   0, 0, 8'h44, 8'h00, 8'h00);
    tbl[52] = mk(0, 8'h40, 8'h00, 1, 0, 0, 0, 0, 0,   0, 0, 8'h44, 8'h40, 8'h00);
    tbl[53] = mk(0, 8'h40, 8'h00, 1, 0, 0, 0, 0, 0,   1, 0, 8'h44, 8'h40, 8'h00);
    tbl[54] = mk(0, 8'h40, 8'h00, 1, 0, 1, 0, 0, 0,   0, 0, 8'h44, 8'h00, 8'h40);
    tbl[55] = mk(0, 8'h40, 8'h00, 1, 0, 0, 0, 0, 0,   0, 0, 8'h44, 8'h40, 8'h40);
    tbl[56] = mk(0, 8'h40, 8'h00, 1, 0, 1, 0, 0, 0,   0, 1, 8'h46, 8'h40, 8'h40);
    tbl[57] = mk(0, 8'h40, 8'h00, 1, 0, 0, 1, 0, 0,   1, 0, 8'h46, 8'h40, 8'h00);

    for (int i = 0; i < 58; i++) begin
      reset = tbl[i].rst; IR = tbl[i].ir; Interrupt_Mask = tbl[i].mask;
      LTIM = tbl[i].ltim; AEOI = tbl[i].aeoi; INTA_STB = tbl[i].inta;
      EOI_NS = tbl[i].ens; EOI_SP = tbl[i].esp; EOI_LEVEL = tbl[i].elev;
      tick();
      check($sformatf("row%0d {int,vv,vec,irr,isr}", i),
            32'({INT, VEC_VALID, VECTOR, IRR, ISR}), 32'(tbl[i].exp_out));
    end
    reset = 1'b0; IR = '0; LTIM = 1'b0; AEOI = 1'b0; INTA_STB = 1'b0;
    EOI_NS = 1'b0; EOI_SP = 1'b0; EOI_LEVEL = '0; Interrupt_Mask = '0;

    // Spurious: IR1 pulse gone before the first INTA
    do_reset();
    IR = 8'h02;
    repeat (4) tick();
    check("spur int_up", 32'(INT), 32'd1);
    IR = 8'h00;
    repeat (4) tick();
    check("spur irr_gone", 32'({INT, IRR}), 32'd0);
    inta_pair();
    check("spur vector", 32'({VEC_VALID, VECTOR}), 32'h147);
    check("spur isr", 32'(ISR), 32'h00);

    // EOI_SP beats EOI_NS; EOI before arbitration in the first-INTA cycle
    do_reset();
    IR = 8'h08;
    repeat (4) tick();
    inta_pair();
    check("nest vec3", 32'({VECTOR, ISR}), 32'h4308);
    IR = 8'h0A;
    repeat (4) tick();
    check("nest int1", 32'({INT, IRR}), 32'h102);
    inta_pair();
    check("nest vec1", 32'({VECTOR, ISR}), 32'h410A);
    EOI_SP = 1'b1; EOI_NS = 1'b1; EOI_LEVEL = 3'd3;
    tick();
    EOI_SP = 1'b0; EOI_NS = 1'b0; EOI_LEVEL = 3'd0;
    check("eoi_sp_wins isr", 32'(ISR), 32'h02);
    IR = 8'h0E;
    repeat (4) tick();
    check("blocked ir2", 32'({INT, IRR}), 32'h004);
    INTA_STB = 1'b1; EOI_NS = 1'b1;
    tick();
    EOI_NS = 1'b0;
    check("eoi_then_arb isr", 32'({ISR, IRR}), 32'h0400);
    tick();
    INTA_STB = 1'b0;
    check("eoi_then_arb vec", 32'({VEC_VALID, VECTOR}), 32'h142);

    // Reset in ACK2 abandons the acknowledge
    IR = 8'h00;
    do_reset();
    IR = 8'h10;
    repeat (4) tick();
    check("rst_ack2 int", 32'(INT), 32'd1);
    INTA_STB = 1'b1;
    tick();
    INTA_STB = 1'b0;
    check("rst_ack2 isr", 32'(ISR), 32'h10);
    reset = 1'b1;
    tick();
    check("rst_ack2 outputs", 32'({INT, VEC_VALID, VECTOR, IRR, ISR}), 32'd0);
    reset = 1'b0;
    INTA_STB = 1'b1;
    tick();
    INTA_STB = 1'b0;
    check("rst_ack2 no_vv", 32'(VEC_VALID), 32'd0);

`ifdef ROTATE_ON_EOI_EN
    // Rotation: after IR0 is served and EOI'd, IR7 outranks IR0
    IR = 8'h00;
    do_reset();
    ROTATE = 1'b1;
    IR = 8'h01;
    repeat (4) tick();
    inta_pair();
    check("rot vec0", 32'({VECTOR, ISR}), 32'h4001);
    EOI_NS = 1'b1;
    tick();
    EOI_NS = 1'b0;
    check("rot eoi", 32'(ISR), 32'h00);
    IR = 8'h00;
    repeat (3) tick();
    IR = 8'h81;
    repeat (4) tick();
    check("rot int", 32'({INT, IRR}), 32'h181);
    inta_pair();
    check("rot ir7_wins", 32'({VECTOR, ISR}), 32'h4780);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
